// File: rtl/spi_device_tx.sv
// Device-side SPI transmitter: shifts words out MSB-first on synchronised sclk_n rises while cs_n is low.
// Pin edge to to_host is 3 clk; tx_ready drops while the one-entry holding buffer is full.
`timescale 1ns/1ps
module spi_device_tx #(
  parameter int             WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic             ena,
  input  logic             sclk_n,
  input  logic             cs_n,
  output logic             to_host,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             frame_done,
  output logic             frame_abort,
  output logic             underrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic             sck_meta, sck_sync, sck_prev;
  logic             cs_meta, cs_sync, cs_prev;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [CW-1:0]    bit_cnt;

  logic             cs_fall, cs_rise, sck_rise;
  logic             last_bit;
  logic             load_req;
  logic [WIDTH-1:0] load_word;

  assign cs_fall  = cs_prev & ~cs_sync;
  assign cs_rise  = ~cs_prev & cs_sync;
  assign sck_rise = ~sck_prev & sck_sync;
  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  // cs_rise outranks a coincident sck_rise, so a word boundary never reloads on deselect.
  assign load_req  = ((state == IDLE) && cs_fall && ena) ||
                     ((state == SHIFT) && !cs_rise && sck_rise && last_bit);
  assign load_word = hold_full ? hold : IDLE_WORD;
  assign tx_ready  = ~hold_full;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state       <= IDLE;
      to_host     <= 1'b0;
      hold        <= '0;
      hold_full   <= 1'b0;
      shift       <= '0;
      bit_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;
      sck_meta    <= 1'b1;
      sck_sync    <= 1'b1;
      sck_prev    <= 1'b1;
      cs_meta     <= 1'b1;
      cs_sync     <= 1'b1;
      cs_prev     <= 1'b1;
    end else begin
      sck_meta    <= sclk_n;
      sck_sync    <= sck_meta;
      sck_prev    <= sck_sync;
      cs_meta     <= cs_n;
      cs_sync     <= cs_meta;
      cs_prev     <= cs_sync;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      underrun    <= 1'b0;

      // Accept only into an empty buffer; a load from hold therefore never collides with it.
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (load_req) begin
        shift      <= load_word;
        to_host    <= load_word[WIDTH-1];
        bit_cnt    <= '0;
        state      <= SHIFT;
        frame_done <= (state == SHIFT);
        if (hold_full) hold_full <= 1'b0;
        else           underrun  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            to_host <= 1'b0;
          end
          SHIFT: begin
            if (cs_rise) begin
              frame_abort <= (bit_cnt != '0);
              to_host     <= 1'b0;
              bit_cnt     <= '0;
              state       <= IDLE;
            end else if (sck_rise) begin
              shift   <= shift << 1;
              to_host <= shift[WIDTH-2];
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_device_tx.sv
// Bench for spi_device_tx: bench-side SPI master plus a word/bit-index model checked every cycle.
`timescale 1ns/1ps
module tb_spi_device_tx;
  localparam int         W    = 8;
  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1;
  logic       ena = 1'b1;
  logic       sclk_n = 1'b1;
  logic       cs_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       to_host, tx_ready, frame_done, frame_abort, underrun;

  spi_device_tx #(.WIDTH(W), .IDLE_WORD(IDLE)) dut (
    .clk(clk), .rst_a(rst_a), .ena(ena), .sclk_n(sclk_n), .cs_n(cs_n),
    .to_host(to_host), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_done(frame_done), .frame_abort(frame_abort), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_done = 0, n_abort = 0, n_under = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the word in flight plus which bit of it is on the line; pins seen two clocks late.
  bit         m_active;
  logic [7:0] m_word;
  int         m_idx;
  logic [7:0] m_hold_q[$];
  logic [2:0] cs_h, sck_h;
  logic       e_to_host, e_done, e_abort, e_under;
  bit         m_acc, cs_f, cs_r, sk_r;

  task automatic m_load();
    if (m_hold_q.size() != 0) m_word = m_hold_q.pop_front();
    else begin
      m_word  = IDLE;
      e_under = 1'b1;
    end
    m_idx    = 0;
    m_active = 1'b1;
  endtask

  always @(posedge clk) begin
    e_done  = 1'b0;
    e_abort = 1'b0;
    e_under = 1'b0;
    if (rst_a) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_word   = 8'h00;
      m_hold_q.delete();
      cs_h     = 3'b111;
      sck_h    = 3'b111;
    end else begin
      cs_f  = cs_h[2] && !cs_h[1];
      cs_r  = !cs_h[2] && cs_h[1];
      sk_r  = !sck_h[2] && sck_h[1];
      m_acc = tx_valid && (m_hold_q.size() == 0);
      if (!m_active) begin
        if (cs_f && ena) m_load();
      end else if (cs_r) begin
        e_abort  = (m_idx != 0);
        m_active = 1'b0;
      end else if (sk_r) begin
        if (m_idx == W - 1) begin
          e_done = 1'b1;
          m_load();
        end else m_idx++;
      end
      if (m_acc) m_hold_q.push_back(tx_data);
      cs_h  = {cs_h[1:0], cs_n};
      sck_h = {sck_h[1:0], sclk_n};
    end
    e_to_host = m_active ? m_word[W-1-m_idx] : 1'b0;
    #1;
    check("to_host", 32'(to_host), 32'(e_to_host));
    check("tx_ready", 32'(tx_ready), 32'(m_hold_q.size() == 0));
    check("frame_done", 32'(frame_done), 32'(e_done));
    check("frame_abort", 32'(frame_abort), 32'(e_abort));
    check("underrun", 32'(underrun), 32'(e_under));
    if (frame_done === 1'b1) n_done++;
    if (frame_abort === 1'b1) n_abort++;
    if (underrun === 1'b1) n_under++;
  end

  task automatic push(input logic [7:0] d);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Master samples to_host just before each sclk_n fall, as the real master would.
  task automatic frame(input int nbits, input int half, output logic [31:0] got);
    got  = '0;
    cs_n = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      got    = {got[30:0], to_host};
      sclk_n = 1'b0;
      repeat (half) @(negedge clk);
      sclk_n = 1'b1;
      repeat (half) @(negedge clk);
    end
    cs_n = 1'b1;
    repeat (half + 4) @(negedge clk);
  endtask

  logic [31:0] got;
  int d0, a0, u0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_to_host", 32'(to_host), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    rst_a = 1'b0;
    repeat (4) @(negedge clk);

    // 1: 0xA5 shifted out, one frame_done
    push(8'hA5);
    check("t1_ready_full", 32'(tx_ready), 32'd0);
    d0 = n_done; a0 = n_abort;
    frame(8, 8, got);
    check("t1_word", got, 32'hA5);
    check("t1_done", 32'(n_done - d0), 32'd1);
    check("t1_abort", 32'(n_abort - a0), 32'd0);

    // 2: empty hold -> IDLE_WORD, underrun at start and at the word boundary
    u0 = n_under;
    frame(8, 8, got);
    check("t2_word", got, 32'hFF);
    check("t2_under", 32'(n_under - u0), 32'd2);

    // 3: back-to-back words inside one frame, trailing word keeps underrun quiet
    push(8'h3C);
    d0 = n_done; u0 = n_under;
    fork
      frame(16, 8, got);
      begin
        push(8'hC3);
        push(8'h55);
      end
    join
    check("t3_words", got, 32'h3CC3);
    check("t3_done", 32'(n_done - d0), 32'd2);
    check("t3_under", 32'(n_under - u0), 32'd0);

    // 4: abort after 3 bits, hold word survives into the next frame
    push(8'h81);
    a0 = n_abort;
    fork
      frame(3, 8, got);
      push(8'h7E);
    join
    check("t4_bits", got, 32'h4);
    check("t4_abort", 32'(n_abort - a0), 32'd1);
    check("t4_to_host", 32'(to_host), 32'd0);
    frame(8, 8, got);
    check("t4_next", got, 32'h7E);

    // 4b: cs_n and sclk_n rise together before any shift -> no abort, no done
    push(8'h99);
    a0 = n_abort; d0 = n_done;
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    check("t4b_msb", 32'(to_host), 32'd1);
    sclk_n = 1'b0;
    repeat (8) @(negedge clk);
    sclk_n = 1'b1;
    cs_n   = 1'b1;
    repeat (12) @(negedge clk);
    check("t4b_abort", 32'(n_abort - a0), 32'd0);
    check("t4b_done", 32'(n_done - d0), 32'd0);

    // 5: ena low at cs_fall ignores the frame and keeps the hold word
    push(8'h5A);
    ena = 1'b0;
    d0 = n_done; a0 = n_abort; u0 = n_under;
    frame(8, 8, got);
    check("t5_word", got, 32'h0);
    check("t5_pulses", 32'((n_done - d0) + (n_abort - a0) + (n_under - u0)), 32'd0);
    check("t5_ready", 32'(tx_ready), 32'd0);
    ena = 1'b1;
    frame(8, 8, got);
    check("t5_retained", got, 32'h5A);

    // 6: reset mid-frame clears the hold buffer and the line
    push(8'h11);
    fork
      begin
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          sclk_n = 1'b0;
          repeat (8) @(negedge clk);
          sclk_n = 1'b1;
          repeat (8) @(negedge clk);
        end
      end
      push(8'h22);
    join
    check("t6_ready_pre", 32'(tx_ready), 32'd0);
    rst_a = 1'b1;
    cs_n  = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    check("t6_to_host", 32'(to_host), 32'd0);
    check("t6_ready", 32'(tx_ready), 32'd1);
    check("t6_done", 32'(frame_done), 32'd0);
    repeat (6) @(negedge clk);

    // loopback-style frames with random words and sclk_n rates
    for (int k = 0; k < 6; k++) begin
      logic [7:0] w;
      int         h;
      w = 8'($urandom);
      h = $urandom_range(4, 9);
      push(w);
      frame(8, h, got);
      check("loop_word", got, 32'(w));
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
